// File: rtl/systolic_array_os_pkg.sv
// Shared definitions for the output-stationary systolic array: FSM state
// encoding, width helper and the flush-length helper.
// No ports; imported by the interface, the PE and the top level.
package systolic_array_os_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    // FLUSH_CYCLES: cycles after the last beat until PE(ROWS-1,COLS-1) has it.
    function automatic int flush_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/systolic_array_os_if.sv
// Job/operand/result bundle of the systolic array.
// master: job source and result sink (drives start, k_len, sgn, accum, a_in,
// b_in, in_valid, res_ready); slave: the array (drives in_ready, res_row,
// res_idx, res_valid, busy, done).
interface systolic_array_os_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 8
);
    import systolic_array_os_pkg::*;

    localparam int IDX_W = clog2_min1(ROWS);

    logic                    start;
    logic [K_W-1:0]          k_len;
    logic                    sgn;
    logic                    accum;
    logic [ROWS*DATA_W-1:0]  a_in;
    logic [COLS*DATA_W-1:0]  b_in;
    logic                    in_valid;
    logic                    in_ready;
    logic [COLS*ACC_W-1:0]   res_row;
    logic [IDX_W-1:0]        res_idx;
    logic                    res_valid;
    logic                    res_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output start, k_len, sgn, accum, a_in, b_in, in_valid, res_ready,
        input  in_ready, res_row, res_idx, res_valid, busy, done
    );

    modport slave (
        input  start, k_len, sgn, accum, a_in, b_in, in_valid, res_ready,
        output in_ready, res_row, res_idx, res_valid, busy, done
    );

endinterface

// File: rtl/systolic_pe.sv
// Purpose: one output-stationary MAC cell; forwards a right and b down.
// Latency: operands and valids pass through in 1 cycle; accumulator updates on the same edge.
// Backpressure: none; a cleared valid is a bubble and leaves the accumulator untouched.
// Ports: i_clk/i_rst, i_clr (sync accumulator clear), i_sgn (signed mode),
// i_a/i_a_vld, i_b/i_b_vld in; o_a/o_a_vld, o_b/o_b_vld forwarded; o_acc result.
module systolic_pe #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_sgn,
    input  logic [DATA_W-1:0] i_a,
    input  logic              i_a_vld,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_b_vld,
    output logic [DATA_W-1:0] o_a,
    output logic              o_a_vld,
    output logic [DATA_W-1:0] o_b,
    output logic              o_b_vld,
    output logic [ACC_W-1:0]  o_acc
);
    logic [DATA_W-1:0]          r_a;
    logic                       r_a_vld;
    logic [DATA_W-1:0]          r_b;
    logic                       r_b_vld;
    logic [ACC_W-1:0]           r_acc;
    logic signed [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0]        w_prod_u;
    logic [ACC_W-1:0]           w_prod_ext;

    // Operands widened to the full product width first so the low 2*DATA_W
    // bits of each product are exact.
    assign w_prod_s = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                      $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});
    assign w_prod_u = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_prod_ext = i_sgn ? ACC_W'(w_prod_s) : ACC_W'(w_prod_u);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_a_vld <= 1'b0;
            r_b     <= '0;
            r_b_vld <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_a     <= i_a;
            r_a_vld <= i_a_vld;
            r_b     <= i_b;
            r_b_vld <= i_b_vld;
            if (i_clr)
                r_acc <= '0;
            else if (i_a_vld && i_b_vld)
                r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_a     = r_a;
    assign o_a_vld = r_a_vld;
    assign o_b     = r_b;
    assign o_b_vld = r_b_vld;
    assign o_acc   = r_acc;

endmodule

// File: rtl/systolic_array_os.sv
// Purpose: ROWS x COLS output-stationary matrix multiply C = A*B, one K-beat per cycle.
// Latency: first result row ROWS+COLS cycles after the last accepted beat, then one row per handshake.
// Backpressure: in_ready only in LOAD; result rows and index hold while res_ready is low.
// Ports: i_clk, i_rst (sync, active high); io_bus (slave side of systolic_array_os_if).
module systolic_array_os
    import systolic_array_os_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    systolic_array_os_if.slave  io_bus
);
    localparam int IDX_W        = clog2_min1(ROWS);
    localparam int FLUSH_CYCLES = flush_cycles(ROWS, COLS);
    localparam int FC_W         = clog2_min1(FLUSH_CYCLES);

    state_t            r_state;
    logic [K_W-1:0]    r_rem;
    logic              r_sgn;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [IDX_W-1:0]  r_res_idx;
    logic              r_in_ready;
    logic              r_res_valid;
    logic              r_busy;
    logic              r_done;

    logic w_beat;
    logic w_clr;

    logic [ROWS-1:0][DATA_W-1:0]            w_a_edge;
    logic [ROWS-1:0]                        w_a_edge_vld;
    logic [COLS-1:0][DATA_W-1:0]            w_b_edge;
    logic [COLS-1:0]                        w_b_edge_vld;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  w_a_pe;
    logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]  w_b_pe;
    logic [ROWS-1:0][COLS-1:0]              w_av_pe;
    logic [ROWS-1:0][COLS-1:0]              w_bv_pe;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]   w_acc;
    logic                                   w_unused_edge;

    assign w_beat = (r_state == ST_LOAD) && io_bus.in_valid;
    // Clearing on the start edge itself; nothing is in flight while IDLE.
    assign w_clr  = (r_state == ST_IDLE) && io_bus.start && !io_bus.accum;

    // Operand skew: row i / column j delayed i / j cycles so beat k meets at
    // PE(i,j) on edge L+i+j.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign w_a_edge[gi]     = io_bus.a_in[gi*DATA_W +: DATA_W];
            assign w_a_edge_vld[gi] = w_beat;
        end else begin : g_delay
            logic [DATA_W-1:0] r_d [gi];
            logic              r_v [gi];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int k = 0; k < gi; k++) begin
                        r_d[k] <= '0;
                        r_v[k] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= io_bus.a_in[gi*DATA_W +: DATA_W];
                    r_v[0] <= w_beat;
                    for (int k = 1; k < gi; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_a_edge[gi]     = r_d[gi-1];
            assign w_a_edge_vld[gi] = r_v[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign w_b_edge[gj]     = io_bus.b_in[gj*DATA_W +: DATA_W];
            assign w_b_edge_vld[gj] = w_beat;
        end else begin : g_delay
            logic [DATA_W-1:0] r_d [gj];
            logic              r_v [gj];
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int k = 0; k < gj; k++) begin
                        r_d[k] <= '0;
                        r_v[k] <= 1'b0;
                    end
                end else begin
                    r_d[0] <= io_bus.b_in[gj*DATA_W +: DATA_W];
                    r_v[0] <= w_beat;
                    for (int k = 1; k < gj; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                    end
                end
            end
            assign w_b_edge[gj]     = r_d[gj-1];
            assign w_b_edge_vld[gj] = r_v[gj-1];
        end
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            logic [DATA_W-1:0] w_a_i;
            logic              w_av_i;
            logic [DATA_W-1:0] w_b_i;
            logic              w_bv_i;
            if (gj == 0) begin : g_a_edge
                assign w_a_i  = w_a_edge[gi];
                assign w_av_i = w_a_edge_vld[gi];
            end else begin : g_a_left
                assign w_a_i  = w_a_pe[gi][gj-1];
                assign w_av_i = w_av_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_i  = w_b_edge[gj];
                assign w_bv_i = w_b_edge_vld[gj];
            end else begin : g_b_up
                assign w_b_i  = w_b_pe[gi-1][gj];
                assign w_bv_i = w_bv_pe[gi-1][gj];
            end
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_clr   (w_clr),
                .i_sgn   (r_sgn),
                .i_a     (w_a_i),
                .i_a_vld (w_av_i),
                .i_b     (w_b_i),
                .i_b_vld (w_bv_i),
                .o_a     (w_a_pe[gi][gj]),
                .o_a_vld (w_av_pe[gi][gj]),
                .o_b     (w_b_pe[gi][gj]),
                .o_b_vld (w_bv_pe[gi][gj]),
                .o_acc   (w_acc[gi][gj])
            );
        end
    end

    // Right-most and bottom pass-through outputs leave the array unconnected.
    assign w_unused_edge = ^{w_a_pe, w_b_pe, w_av_pe, w_bv_pe};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_sgn       <= 1'b0;
            r_flush_cnt <= '0;
            r_res_idx   <= '0;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (io_bus.start) begin
                    r_rem  <= io_bus.k_len;
                    r_sgn  <= io_bus.sgn;
                    r_busy <= 1'b1;
                    if (io_bus.k_len == '0) begin
                        r_state     <= ST_DRAIN;
                        r_res_valid <= 1'b1;
                        r_res_idx   <= '0;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_in_ready <= 1'b1;
                    end
                end
                ST_LOAD: if (io_bus.in_valid) begin
                    r_rem <= r_rem - K_W'(1);
                    if (r_rem == K_W'(1)) begin
                        r_state     <= ST_FLUSH;
                        r_in_ready  <= 1'b0;
                        r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == '0) begin
                        r_state     <= ST_DRAIN;
                        r_res_valid <= 1'b1;
                        r_res_idx   <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - FC_W'(1);
                    end
                end
                ST_DRAIN: if (io_bus.res_ready) begin
                    if (r_res_idx == IDX_W'(ROWS - 1)) begin
                        r_state     <= ST_IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_res_idx   <= '0;
                    end else begin
                        r_res_idx <= r_res_idx + IDX_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_idx   = r_res_idx;
    assign io_bus.res_row   = w_acc[r_res_idx];
    assign io_bus.busy      = r_busy;
    assign io_bus.done      = r_done;

endmodule

// File: tb/tb_systolic_array_os.sv
// Bench for systolic_array_os: directed matrix jobs plus randomized jobs with
// bubbles, stalls and stray start/in_valid, checked against a matrix-product model.
module tb_systolic_array_os;
    localparam int ROWS   = 3;
    localparam int COLS   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int K_W    = 5;
    localparam int KMAX   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;

    logic [DATA_W-1:0] a_mat [ROWS][KMAX];
    logic [DATA_W-1:0] b_mat [KMAX][COLS];
    logic [ACC_W-1:0]  mc    [ROWS][COLS];
    logic [ACC_W-1:0]  got   [ROWS][COLS];

    systolic_array_os_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
                           .ACC_W(ACC_W), .K_W(K_W)) bus ();

    systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W),
                        .ACC_W(ACC_W), .K_W(K_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_operands;
        for (int i = 0; i < ROWS; i++) bus.a_in[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        for (int j = 0; j < COLS; j++) bus.b_in[j*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    task automatic clear_mats;
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = '0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = '0;
    endtask

    task automatic rand_mats;
        for (int i = 0; i < ROWS; i++) for (int k = 0; k < KMAX; k++) a_mat[i][k] = DATA_W'($urandom);
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < COLS; j++) b_mat[k][j] = DATA_W'($urandom);
    endtask

    // bmode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random bubbles.
    task automatic run_job(input int k, input bit s, input bit acc, input int bmode, input int stall_pct);
        int     beat, guard, llast, row, dcyc;
        longint p;
        bit     v;
        // Reference: C (+)= A*B modulo 2^ACC_W.
        for (int i = 0; i < ROWS; i++)
            for (int j = 0; j < COLS; j++) begin
                if (!acc) mc[i][j] = '0;
                for (int kk = 0; kk < k; kk++) begin
                    if (s) p = longint'($signed(a_mat[i][kk])) * longint'($signed(b_mat[kk][j]));
                    else   p = longint'(a_mat[i][kk]) * longint'(b_mat[kk][j]);
                    mc[i][j] = mc[i][j] + p[ACC_W-1:0];
                end
            end

        bus.start = 1'b1; bus.k_len = K_W'(k); bus.sgn = s; bus.accum = acc;
        tick;
        // Any later start pulse would clear and restart a 1-beat job if not ignored.
        bus.start = 1'b0; bus.accum = 1'b0; bus.k_len = K_W'(1); bus.sgn = ~s;
        chk("busy_after_start", bus.busy, 1);

        beat = 0; guard = 0; llast = -1;
        while (beat < k && guard < 500) begin
            case (bmode)
                0:       v = 1'b1;
                1:       v = (guard % 4 == 0) || (guard % 4 == 3);
                default: v = ($urandom_range(2) != 0);
            endcase
            garbage_operands();
            if (v) begin
                for (int i = 0; i < ROWS; i++) bus.a_in[i*DATA_W +: DATA_W] = a_mat[i][beat];
                for (int j = 0; j < COLS; j++) bus.b_in[j*DATA_W +: DATA_W] = b_mat[beat][j];
            end
            bus.in_valid = v;
            bus.start    = ($urandom_range(3) == 0);
            if (v && bus.in_ready) begin
                if (beat == k - 1) llast = cyc;
                beat++;
            end
            tick;
            guard++;
        end
        if (beat < k) chk("load_timeout", beat, k);

        guard = 0;
        while (!bus.res_valid && guard < 100) begin
            garbage_operands();
            bus.in_valid = $urandom_range(1);
            bus.start    = ($urandom_range(3) == 0);
            tick;
            guard++;
        end
        chk("res_valid_rise", bus.res_valid, 1);
        if (k > 0) chk("latency", cyc - llast, ROWS + COLS);

        row = 0; dcyc = 0;
        while (row < ROWS && dcyc < 200) begin
            garbage_operands();
            bus.in_valid = $urandom_range(1);
            bus.start    = ($urandom_range(3) == 0);
            chk("drain_valid", bus.res_valid, 1);
            chk("drain_idx", bus.res_idx, row);
            for (int j = 0; j < COLS; j++) begin
                got[row][j] = bus.res_row[j*ACC_W +: ACC_W];
                chk($sformatf("row%0d_col%0d", row, j), got[row][j], mc[row][j]);
            end
            if (stall_pct > 0 && dcyc < 3) bus.res_ready = 1'b0;
            else bus.res_ready = ($urandom_range(99) >= stall_pct);
            if (bus.res_ready) row++;
            tick;
            dcyc++;
        end
        if (row < ROWS) chk("drain_timeout", row, ROWS);
        bus.res_ready = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("idle_busy", bus.busy, 0);
        chk("idle_res_valid", bus.res_valid, 0);
        tick;
        chk("done_single", bus.done, 0);
    endtask

    task automatic set_t1;
        clear_mats();
        a_mat[0][0] = 8'd1; a_mat[0][1] = 8'd2; a_mat[1][0] = 8'd3; a_mat[1][1] = 8'd4;
        b_mat[0][0] = 8'd5; b_mat[0][1] = 8'd6; b_mat[1][0] = 8'd7; b_mat[1][1] = 8'd8;
    endtask

    task automatic chk_2x2(input string tag, input logic [63:0] c00, input logic [63:0] c01,
                           input logic [63:0] c10, input logic [63:0] c11);
        chk({tag, "_c00"}, got[0][0], c00);
        chk({tag, "_c01"}, got[0][1], c01);
        chk({tag, "_c10"}, got[1][0], c10);
        chk({tag, "_c11"}, got[1][1], c11);
    endtask

    initial begin
        int  k, done_seen;
        logic [63:0] m;
        m = (64'd1 << ACC_W);
        bus.start = 1'b0; bus.k_len = '0; bus.sgn = 1'b0; bus.accum = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
        tick; tick;
        chk("rst_busy", bus.busy, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_res_idx", bus.res_idx, 0);
        chk("rst_res_row", bus.res_row, 0);
        rst = 1'b0;
        tick;

        set_t1();
        run_job(2, 1'b0, 1'b0, 0, 0);
        chk_2x2("t1", 19, 22, 43, 50);
        run_job(2, 1'b0, 1'b1, 0, 0);
        chk_2x2("t2acc", 38, 44, 86, 100);
        run_job(2, 1'b0, 1'b0, 0, 0);
        chk_2x2("t2clr", 19, 22, 43, 50);

        clear_mats();
        a_mat[0][0] = 8'hFD; a_mat[1][1] = 8'd2;
        b_mat[0][0] = 8'd5;  b_mat[1][1] = 8'hF9;
        run_job(2, 1'b1, 1'b0, 0, 0);
        chk_2x2("t3s", m - 15, 0, 0, m - 14);
        run_job(2, 1'b0, 1'b0, 0, 0);
        chk_2x2("t3u", 1265, 0, 0, 498);

        set_t1();
        run_job(2, 1'b0, 1'b0, 1, 40);
        chk_2x2("t4", 19, 22, 43, 50);
        run_job(0, 1'b0, 1'b1, 0, 0);
        chk_2x2("t5", 19, 22, 43, 50);

        // Reset in the middle of FLUSH.
        bus.start = 1'b1; bus.k_len = K_W'(2); bus.sgn = 1'b0; bus.accum = 1'b0;
        tick;
        bus.start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < ROWS; i++) bus.a_in[i*DATA_W +: DATA_W] = a_mat[i][b];
            for (int j = 0; j < COLS; j++) bus.b_in[j*DATA_W +: DATA_W] = b_mat[b][j];
            bus.in_valid = 1'b1;
            tick;
        end
        bus.in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_res_valid", bus.res_valid, 0);
        chk("t6_done", bus.done, 0);
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done || bus.res_valid) done_seen++;
            tick;
        end
        chk("t6_no_done", done_seen, 0);
        for (int i = 0; i < ROWS; i++) for (int j = 0; j < COLS; j++) mc[i][j] = '0;
        run_job(0, 1'b0, 1'b1, 0, 0);
        chk_2x2("t6zero", 0, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            rand_mats();
            k = $urandom_range(12);
            run_job(k, 1'($urandom_range(1)), 1'($urandom_range(1)), 2, 30);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
Parameterised ROWS x COLS output-stationary systolic matrix-multiply array with a streaming input handshake, internal operand skew, signed/unsigned mode and an optional accumulate-over-jobs mode. It replaces the fixed 2x2 element-wise MAC array. One job computes C = A(ROWS x K) * B(K x COLS), one K-beat per cycle. Results drain one row per cycle over a valid/ready port.

Parameters:
ROWS, 4, PE rows (>=1)
COLS, 4, PE columns (>=1)
DATA_W, 16, operand width
ACC_W, 40, accumulator width (must be >= 2*DATA_W)
K_W, 8, width of the job length field

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  job start pulse; ignored unless state is IDLE
k_len  in  K_W  beats in the job; sampled on start
sgn  in  1  1 = signed operands; sampled on start
accum  in  1  1 = keep accumulators from the previous job; sampled on start
a_in  in  ROWS*DATA_W  column k of A; row i at bits [i*DATA_W +: DATA_W]
b_in  in  COLS*DATA_W  row k of B; column j at bits [j*DATA_W +: DATA_W]
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
res_row  out  COLS*ACC_W  C row res_idx; column j at [j*ACC_W +: ACC_W]
res_idx  out  clog2(ROWS) (min 1)  row index of res_row
res_valid  out  1  result row valid
res_ready  in  1  result row consumed when res_valid && res_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the last row is consumed

Behaviour:
- Reset (synchronous): state IDLE, all accumulators, skew registers and PE valid bits 0. in_ready, res_valid, busy and done are 0. res_row and res_idx are 0. Reset mid-job aborts the job with no done pulse.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE, start=1: latch k_len, sgn and accum. If accum=0, clear all accumulators on the same edge. Go to LOAD, or to DRAIN if k_len=0.
- LOAD: in_ready=1. Each accepted beat decrements the remaining count. A cycle with in_valid=0 is a bubble: no accumulation, and the valid bit propagates through the array. The edge accepting the final beat moves to FLUSH.
- FLUSH: lasts exactly ROWS+COLS-1 cycles, then DRAIN.
- Timing: if the last beat is accepted in cycle L, res_valid first rises in cycle L+ROWS+COLS.
- Skew: a row i is delayed i cycles and b column j is delayed j cycles, each carrying a valid bit.
- PE(i,j) registers a to the right and b downward, both with valid. It accumulates only when the incoming valid is set. Beat k's operands meet at PE(i,j) simultaneously.
- Arithmetic: product is 2*DATA_W bits, signed or unsigned per the latched sgn. It is sign- or zero-extended to ACC_W. Accumulation wraps modulo 2^ACC_W with no saturation.
- DRAIN: res_valid=1. res_idx starts at 0; res_row holds row res_idx. Both are held stable while res_ready=0. On a handshake the index advances. Handshake on row ROWS-1 returns to IDLE with done=1 in the following cycle.
- Accumulators are not cleared after DRAIN, so a following accum=1 job adds onto them.
- start while busy is ignored. in_valid outside LOAD is ignored.

Decomposition:
- Shared package/header holds the state encoding, the FLUSH_CYCLES = ROWS+COLS-1 constant, and a clog2 function.
- Sub-module systolic_pe (params DATA_W, ACC_W) contains:
  - a/b/valid pass-through registers;
  - the signed/unsigned multiplier;
  - the accumulator, with a clear input and an accumulator read port.
- The top level instantiates a ROWS x COLS generate grid plus the skew shift registers, the FSM and the drain mux.

Test Plan:
1. ROWS=COLS=2, unsigned, accum=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]], k_len=2, back-to-back beats -> res_valid exactly ROWS+COLS cycles after the last accept. Row0={19,22}, row1={43,50}, then a done pulse.
2. Same job repeated with accum=1 -> row0={38,44}, row1={86,100}. Then accum=0 -> {19,22},{43,50}.
3. sgn=1, A=[[-3,0],[0,2]], B=[[5,0],[0,-7]] -> row0={-15,0}, row1={0,-14}, sign-extended to ACC_W. The same bit patterns with sgn=0 give unsigned products.
4. Bubbles and backpressure: in_valid toggles 1,0,0,1 during test 1, and res_ready is held low 3 cycles in DRAIN -> identical results. res_row/res_idx stay stable while stalled, and no row is lost or duplicated.
5. k_len=0 with accum=1 after test 1 -> straight to DRAIN with {19,22},{43,50}. start pulsed while busy is ignored.
6. rst asserted mid-FLUSH -> next cycle busy=0 and res_valid=0, no done pulse. A following accum=1 job with k_len=0 returns all zeros.
